// File: rtl/wpm_calculator_if.sv
// wpm_calculator_if: request/result bundle between the game logic and the WPM engine.
//   master: drives sample, word_count and the BCD time digits; observes the results.
//   slave : the calculator; drives busy, valid, wpm_integer, wpm_decimal, short, sat
//           (plus peak_integer/peak_decimal when WPM_PEAK_EN is defined).
interface wpm_calculator_if #(
    parameter int unsigned CNT_W = 11,
    parameter int unsigned INT_W = 10
);
    logic             sample;
    logic [CNT_W-1:0] word_count;
    logic [3:0]       minutes;
    logic [3:0]       sec_high;
    logic [3:0]       sec_low;
    logic [3:0]       tenths;
    logic             busy;
    logic             valid;
    logic [INT_W-1:0] wpm_integer;
    logic [6:0]       wpm_decimal;
    logic             short;
    logic             sat;
`ifdef WPM_PEAK_EN
    logic [INT_W-1:0] peak_integer;
    logic [6:0]       peak_decimal;

    modport master (
        output sample, word_count, minutes, sec_high, sec_low, tenths,
        input  busy, valid, wpm_integer, wpm_decimal, short, sat,
        input  peak_integer, peak_decimal
    );
    modport slave (
        input  sample, word_count, minutes, sec_high, sec_low, tenths,
        output busy, valid, wpm_integer, wpm_decimal, short, sat,
        output peak_integer, peak_decimal
    );
`else
    modport master (
        output sample, word_count, minutes, sec_high, sec_low, tenths,
        input  busy, valid, wpm_integer, wpm_decimal, short, sat
    );
    modport slave (
        input  sample, word_count, minutes, sec_high, sec_low, tenths,
        output busy, valid, wpm_integer, wpm_decimal, short, sat
    );
`endif
endinterface

// File: rtl/wpm_calculator.sv
// wpm_calculator: words-per-minute engine with a shared multi-cycle restoring divider.
//   WPM*100 = word_count*60000 / elapsed_tenths, then split by 100 into integer and
//   hundredths fields, with saturation and a minimum-time guard.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - wpm_calculator_if.slave (sample/inputs in; busy/valid/result fields out)
// Optional feature: define WPM_PEAK_EN to add peak_integer/peak_decimal tracking.
module wpm_calculator #(
    parameter int unsigned CNT_W      = 11,
    parameter int unsigned INT_W      = 10,
    parameter int unsigned MIN_TENTHS = 10
) (
    input  logic              clk,
    input  logic              reset,
    wpm_calculator_if.slave   bus
);
    localparam int unsigned NUM_W     = CNT_W + 16;
    localparam int unsigned T_W       = 13;
    localparam int unsigned STEP_W    = $clog2(NUM_W);
    localparam int unsigned SCALE     = 60000;
    localparam int unsigned SPLIT_DIV = 100;

    typedef enum logic [2:0] {IDLE, CONVERT, DIV, SPLIT, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        min_q;
    logic [3:0]        sh_q;
    logic [3:0]        sl_q;
    logic [3:0]        tn_q;
    logic              short_q;
    logic [NUM_W-1:0]  quo;
    logic [T_W-1:0]    rem;
    logic [T_W-1:0]    divisor;
    logic [STEP_W-1:0] step;

    logic [T_W-1:0]    t_c;
    logic [T_W:0]      rem_sh_c;
    logic              ge_c;
    logic [T_W-1:0]    rem_nx_c;
    logic [NUM_W-1:0]  quo_nx_c;
    logic              over_c;
    logic [INT_W-1:0]  res_int_c;
    logic [6:0]        res_dec_c;

    // Elapsed time in tenths, one restoring-division step, and final result shaping.
    // The remainder stays below the divisor (< 2^13), so one extra bit covers the shift.
    always_comb begin
        t_c      = T_W'(min_q) * T_W'(600) + T_W'(sh_q) * T_W'(100)
                 + T_W'(sl_q) * T_W'(10) + T_W'(tn_q);
        rem_sh_c = {rem, quo[NUM_W-1]};
        ge_c     = (rem_sh_c >= {1'b0, divisor});
        rem_nx_c = ge_c ? T_W'(rem_sh_c - {1'b0, divisor}) : rem_sh_c[T_W-1:0];
        quo_nx_c = {quo[NUM_W-2:0], ge_c};
        over_c   = |quo[NUM_W-1:INT_W];
        res_int_c = '0;
        res_dec_c = '0;
        if (!short_q) begin
            res_int_c = over_c ? '1 : quo[INT_W-1:0];
            res_dec_c = over_c ? 7'd99 : rem[6:0];
        end
    end

    // Control FSM, divider datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt_q           <= '0;
            min_q           <= '0;
            sh_q            <= '0;
            sl_q            <= '0;
            tn_q            <= '0;
            short_q         <= 1'b0;
            quo             <= '0;
            rem             <= '0;
            divisor         <= '0;
            step            <= '0;
            bus.busy        <= 1'b0;
            bus.valid       <= 1'b0;
            bus.wpm_integer <= '0;
            bus.wpm_decimal <= '0;
            bus.short       <= 1'b0;
            bus.sat         <= 1'b0;
`ifdef WPM_PEAK_EN
            bus.peak_integer <= '0;
            bus.peak_decimal <= '0;
`endif
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sample) begin
                        cnt_q    <= bus.word_count;
                        min_q    <= bus.minutes;
                        sh_q     <= bus.sec_high;
                        sl_q     <= bus.sec_low;
                        tn_q     <= bus.tenths;
                        bus.busy <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (t_c < T_W'(MIN_TENTHS)) begin
                        short_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        short_q <= 1'b0;
                        quo     <= NUM_W'(cnt_q) * NUM_W'(SCALE);
                        rem     <= '0;
                        divisor <= t_c;
                        step    <= STEP_W'(NUM_W - 1);
                        state   <= DIV;
                    end
                end
                DIV: begin
                    quo <= quo_nx_c;
                    if (step == '0) begin
                        // Quotient q = WPM*100 stays in quo as the next dividend.
                        rem     <= '0;
                        divisor <= T_W'(SPLIT_DIV);
                        step    <= STEP_W'(NUM_W - 1);
                        state   <= SPLIT;
                    end else begin
                        rem  <= rem_nx_c;
                        step <= step - STEP_W'(1);
                    end
                end
                SPLIT: begin
                    quo <= quo_nx_c;
                    rem <= rem_nx_c;
                    if (step == '0) begin
                        state <= DONE;
                    end else begin
                        step <= step - STEP_W'(1);
                    end
                end
                DONE: begin
                    bus.wpm_integer <= res_int_c;
                    bus.wpm_decimal <= res_dec_c;
                    bus.short       <= short_q;
                    bus.sat         <= !short_q && over_c;
                    bus.valid       <= 1'b1;
                    bus.busy        <= 1'b0;
`ifdef WPM_PEAK_EN
                    if ({res_int_c, res_dec_c} > {bus.peak_integer, bus.peak_decimal}) begin
                        bus.peak_integer <= res_int_c;
                        bus.peak_decimal <= res_dec_c;
                    end
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wpm_calculator.sv
// tb_wpm_calculator: directed + small random checks of wpm_calculator using a
// scoreboard of expected results pushed at sample time and popped at valid.
module tb_wpm_calculator;
    localparam int unsigned CNT_W      = 11;
    localparam int unsigned INT_W      = 10;
    localparam int unsigned MIN_TENTHS = 10;
    localparam int L_NORM  = 2 * (CNT_W + 16) + 2;
    localparam int L_SHORT = 2;
    localparam int SAT_MAX = (1 << INT_W) - 1;

    typedef struct {
        int ival;
        int dval;
        int shrt;
        int st;
        int lat;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   peak_i = 0;
    int   peak_d = 0;

    always #5 clk = ~clk;

    wpm_calculator_if #(.CNT_W(CNT_W), .INT_W(INT_W)) bus ();

    wpm_calculator #(
        .CNT_W(CNT_W), .INT_W(INT_W), .MIN_TENTHS(MIN_TENTHS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int wc, input int m, input int sh, input int sl, input int tn);
        exp_t   e;
        longint t;
        longint q;
        e.ival = 0; e.dval = 0; e.shrt = 0; e.st = 0; e.lat = L_NORM;
        t = longint'(m * 600 + sh * 100 + sl * 10 + tn);
        if (t < longint'(MIN_TENTHS)) begin
            e.shrt = 1;
            e.lat  = L_SHORT;
        end else begin
            q = (longint'(wc) * 60000) / t;
            if (q / 100 > longint'(SAT_MAX)) begin
                e.ival = SAT_MAX;
                e.dval = 99;
                e.st   = 1;
            end else begin
                e.ival = int'(q / 100);
                e.dval = int'(q % 100);
            end
        end
        return e;
    endfunction

    // Called at a negedge: presents a request, accepts at the next edge, then scrambles inputs.
    task automatic start(input int wc, input int m, input int sh, input int sl, input int tn);
        sb.push_back(model(wc, m, sh, sl, tn));
        bus.word_count = CNT_W'(wc);
        bus.minutes    = 4'(m);
        bus.sec_high   = 4'(sh);
        bus.sec_low    = 4'(sl);
        bus.tenths     = 4'(tn);
        bus.sample     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.sample = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        bus.word_count = CNT_W'($urandom);
        bus.minutes    = 4'($urandom_range(0, 9));
        bus.sec_high   = 4'($urandom_range(0, 5));
        bus.sec_low    = 4'($urandom_range(0, 9));
        bus.tenths     = 4'($urandom_range(0, 9));
    endtask

    // Waits (bounded) for valid; optionally fires an extra sample at cycle 'inject'.
    task automatic finish_one(input int inject);
        exp_t e;
        int   cyc = 0;
        while (bus.valid !== 1'b1 && cyc < 200) begin
            bus.sample = (cyc == inject);
            if (cyc == inject) check("busy_at_inject", 32'(bus.busy), 32'd1);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        bus.sample = 1'b0;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        last_e = e;
        check("latency", 32'(cyc), 32'(e.lat));
        check("valid", 32'(bus.valid), 32'd1);
        check("busy_at_valid", 32'(bus.busy), 32'd0);
        check("wpm_integer", 32'(bus.wpm_integer), 32'(e.ival));
        check("wpm_decimal", 32'(bus.wpm_decimal), 32'(e.dval));
        check("short", 32'(bus.short), 32'(e.shrt));
        check("sat", 32'(bus.sat), 32'(e.st));
        if (e.ival * 100 + e.dval > peak_i * 100 + peak_d) begin
            peak_i = e.ival;
            peak_d = e.dval;
        end
`ifdef WPM_PEAK_EN
        check("peak_integer", 32'(bus.peak_integer), 32'(peak_i));
        check("peak_decimal", 32'(bus.peak_decimal), 32'(peak_d));
`endif
    endtask

    task automatic quiet(input int n, input string tag);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.valid === 1'b1) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.sample     = 1'b0;
        bus.word_count = '0;
        bus.minutes    = '0;
        bus.sec_high   = '0;
        bus.sec_low    = '0;
        bus.tenths     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_int", 32'(bus.wpm_integer), 32'd0);
        check("rst_dec", 32'(bus.wpm_decimal), 32'd0);
        check("rst_short", 32'(bus.short), 32'd0);
        check("rst_sat", 32'(bus.sat), 32'd0);
        reset = 1'b0;

        // 10 words in 1:00.0 -> 10.00
        start(10, 1, 0, 0, 0);
        finish_one(-1);

        // 7 words in 0:09.0 -> 46.66, with an ignored sample mid-calculation
        start(7, 0, 0, 9, 0);
        finish_one(10);
        quiet(70, "no_extra_valid");
        check("hold_int", 32'(bus.wpm_integer), 32'(last_e.ival));
        check("hold_dec", 32'(bus.wpm_decimal), 32'(last_e.dval));

        // 10.00 again: peak must stay at 46.66
        start(10, 1, 0, 0, 0);
        finish_one(-1);

        // Short path: 0:00.5 and the boundary 0:00.9
        start(3, 0, 0, 0, 5);
        finish_one(-1);
        start(100, 0, 0, 0, 9);
        finish_one(-1);

        // Saturation at exactly MIN_TENTHS, then a back-to-back sample in the valid cycle
        start(2047, 0, 0, 1, 0);
        finish_one(-1);
        start(7, 0, 0, 9, 0);
        finish_one(-1);

        // Reset during DIV aborts the calculation
        start(10, 1, 0, 0, 0);
        void'(sb.pop_back());
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_valid", 32'(bus.valid), 32'd0);
        check("abort_int", 32'(bus.wpm_integer), 32'd0);
        check("abort_dec", 32'(bus.wpm_decimal), 32'd0);
        check("abort_short", 32'(bus.short), 32'd0);
        check("abort_sat", 32'(bus.sat), 32'd0);
`ifdef WPM_PEAK_EN
        check("abort_peak_int", 32'(bus.peak_integer), 32'd0);
        check("abort_peak_dec", 32'(bus.peak_decimal), 32'd0);
`endif
        peak_i = 0;
        peak_d = 0;
        reset  = 1'b0;
        quiet(70, "no_valid_after_abort");
        start(7, 0, 0, 9, 0);
        finish_one(-1);

        // A few random requests with valid BCD digits
        for (int k = 0; k < 4; k++) begin
            start(int'($urandom_range(0, 2047)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 9)));
            finish_one(-1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
